// File: rtl/lsu_access_ctrl_if.sv
// Request / response / memory bus bundle for the LSU access sequencer.
interface lsu_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_size, req_signed, base, offset, wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_size, req_signed, base, offset, wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_access_ctrl.sv
// Load/store sequencer in front of a word-wide memory: base+offset addressing,
// sub-word loads with extension, sub-word stores via read-modify-write.
module lsu_access_ctrl #(
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_access_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_e;

    // Only what the later states need: the byte lane and the sub-word store data.
    // Word store data goes straight to mem_wdata at accept.
    typedef struct packed {
        logic        store;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lo;
        logic [15:0] wd;
    } req_t;

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] byte_addr, eff_addr, load_val, merged;
    logic        misalign, req_err, accept;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign accept = bus.req_valid && (state_q == IDLE);

    // Address formation, alignment check and optional forced alignment.
    always_comb begin
        byte_addr = bus.base + bus.offset;
        misalign  = ((bus.req_size == 2'b01) && byte_addr[0]) ||
                    ((bus.req_size == 2'b10) && (byte_addr[1:0] != 2'b00));
        eff_addr  = byte_addr;
        if (!ERR_ON_MISALIGN) begin
            if (bus.req_size == 2'b01)      eff_addr[0]   = 1'b0;
            else if (bus.req_size == 2'b10) eff_addr[1:0] = 2'b00;
        end
        req_err = (bus.req_size == 2'b11) || (ERR_ON_MISALIGN && misalign);
    end

    // Lane extraction for loads and lane insertion for sub-word stores.
    always_comb begin
        lane_b = bus.mem_rdata[{req_q.lo, 3'b000} +: 8];
        lane_h = bus.mem_rdata[{req_q.lo[1], 4'b0000} +: 16];
        case (req_q.size)
            2'b00:   load_val = req_q.sgn ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            2'b01:   load_val = req_q.sgn ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            default: load_val = bus.mem_rdata;
        endcase
        merged = bus.mem_rdata;
        if (req_q.size == 2'b00) merged[{req_q.lo, 3'b000} +: 8]     = req_q.wd[7:0];
        else                     merged[{req_q.lo[1], 4'b0000} +: 16] = req_q.wd;
    end

    // FSM state register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept && !req_err)
                       state_d = (bus.req_store && bus.req_size == 2'b10) ? WRITE : READ;
            READ:  state_d = WAIT;
            WAIT:  state_d = req_q.store ? WRITE : IDLE;
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; mem_we follows the state so reset drops it asynchronously.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.mem_we    = (state_q == WRITE);
    end

    // Datapath next values: request latch, memory address/data, response.
    always_comb begin
        req_d       = req_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (accept) begin
                req_d = '{store: bus.req_store, size: bus.req_size, sgn: bus.req_signed,
                          lo: eff_addr[1:0], wd: bus.wdata[15:0]};
                if (req_err) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    mem_addr_d = {2'b00, eff_addr[31:2]};
                    if (bus.req_store && bus.req_size == 2'b10) mem_wdata_d = bus.wdata;
                end
            end
            WAIT: if (req_q.store) begin
                mem_wdata_d = merged;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = load_val;
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = '0;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed vector bench for lsu_access_ctrl: one instance erroring on
// misalignment, one forcing alignment, each with its own word memory.
module tb_lsu_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_access_ctrl_if m1();
    lsu_access_ctrl_if m0();

    lsu_access_ctrl #(.ERR_ON_MISALIGN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));
    lsu_access_ctrl #(.ERR_ON_MISALIGN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));

    // shared request drive, steered to one instance by sel (0 = dut1, 1 = dut0)
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_store = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] base = '0, offset = '0, wdata = '0;

    assign m1.req_valid = req_valid & ~sel;
    assign m0.req_valid = req_valid & sel;
    assign m1.req_store = req_store;   assign m0.req_store = req_store;
    assign m1.req_size = req_size;     assign m0.req_size = req_size;
    assign m1.req_signed = req_signed; assign m0.req_signed = req_signed;
    assign m1.base = base;             assign m0.base = base;
    assign m1.offset = offset;         assign m0.offset = offset;
    assign m1.wdata = wdata;           assign m0.wdata = wdata;

    // word memories: write at end of WRITE cycle, read data one cycle after address
    logic [31:0] mem1 [0:255];
    logic [31:0] mem0 [0:255];
    logic [31:0] rd1 = '0, rd0 = '0;
    always @(posedge clk) begin
        if (m1.mem_we) mem1[m1.mem_addr[7:0]] <= m1.mem_wdata;
        rd1 <= mem1[m1.mem_addr[7:0]];
        if (m0.mem_we) mem0[m0.mem_addr[7:0]] <= m0.mem_wdata;
        rd0 <= mem0[m0.mem_addr[7:0]];
    end
    assign m1.mem_rdata = rd1;
    assign m0.mem_rdata = rd0;

    logic        o_ready, o_valid, o_err, o_we;
    logic [31:0] o_data, o_maddr, o_wdata;
    assign o_ready = sel ? m0.req_ready : m1.req_ready;
    assign o_valid = sel ? m0.rsp_valid : m1.rsp_valid;
    assign o_err   = sel ? m0.rsp_err   : m1.rsp_err;
    assign o_we    = sel ? m0.mem_we    : m1.mem_we;
    assign o_data  = sel ? m0.rsp_data  : m1.rsp_data;
    assign o_maddr = sel ? m0.mem_addr  : m1.mem_addr;
    assign o_wdata = sel ? m0.mem_wdata : m1.mem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        sel;
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wd;
        logic        err;
        logic [31:0] data;
        logic [3:0]  lat;
        logic [31:0] maddr;
        logic [31:0] wword;
    } vec_t;

    localparam int NV = 30;
    vec_t tv [NV];

    // issue one request, follow it to its response, compare everything seen
    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          we_cnt;
        logic [31:0] wword;
        bit          got;
        @(negedge clk);
        sel = v.sel;
        #1;
        chk($sformatf("v%0d ready_idle", idx), {31'b0, o_ready}, 32'd1);
        req_valid = 1'b1; req_store = v.st; req_size = v.sz; req_signed = v.sg;
        base = v.base; offset = v.off; wdata = v.wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = 1'($urandom); req_signed = 1'($urandom);
        base = $urandom; offset = $urandom; wdata = $urandom;
        lat = 0; we_cnt = 0; wword = '0; got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && !v.err) begin
                chk($sformatf("v%0d mem_addr", idx), o_maddr, v.maddr);
                chk($sformatf("v%0d ready_busy", idx), {31'b0, o_ready}, 32'd0);
            end
            if (o_we) begin
                we_cnt++;
                wword = o_wdata;
            end
            if (o_valid) got = 1'b1;
        end
        chk($sformatf("v%0d rsp_seen", idx), {31'b0, got}, 32'd1);
        chk($sformatf("v%0d latency", idx), lat, {28'b0, v.lat});
        chk($sformatf("v%0d rsp_data", idx), o_data, v.data);
        chk($sformatf("v%0d rsp_err", idx), {31'b0, o_err}, {31'b0, v.err});
        chk($sformatf("v%0d we_count", idx), we_cnt, (v.st && !v.err) ? 1 : 0);
        if (v.st && !v.err) chk($sformatf("v%0d mem_wdata", idx), wword, v.wword);
        @(negedge clk);
        chk($sformatf("v%0d rsp_pulse", idx), {31'b0, o_valid}, 32'd0);
    endtask

    initial begin
        vec_t        v;
        bit          bad;
        // sel st sz sg base off wdata err data lat maddr wword
        tv[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0, 4'd2, 32'h41, 32'hDEADBEEF};
        tv[1]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h4, 32'h0, 1'b0, 32'hDEADBEEF, 4'd3, 32'h41, 32'h0};
        tv[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h104, 32'h0, 32'h80FF7F01, 1'b0, 32'h0, 4'd2, 32'h41, 32'h80FF7F01};
        tv[3]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h100, 32'h7, 32'h0, 1'b0, 32'hFFFFFF80, 4'd3, 32'h41, 32'h0};
        tv[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h100, 32'h7, 32'h0, 1'b0, 32'h00000080, 4'd3, 32'h41, 32'h0};
        tv[5]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h100, 32'h6, 32'h0, 1'b0, 32'hFFFF80FF, 4'd3, 32'h41, 32'h0};
        tv[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h100, 32'h5, 32'h0, 1'b0, 32'h0000007F, 4'd3, 32'h41, 32'h0};
        tv[7]  = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h104, 32'h0, 32'h0, 1'b0, 32'h00007F01, 4'd3, 32'h41, 32'h0};
        tv[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h106, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 4'd3, 32'h41, 32'h0};
        tv[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h0, 32'h11223344, 1'b0, 32'h0, 4'd2, 32'h20, 32'h11223344};
        tv[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h80, 32'h1, 32'h000000AB, 1'b0, 32'h0, 4'd4, 32'h20, 32'h1122AB44};
        tv[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 32'h1122AB44, 4'd3, 32'h20, 32'h0};
        tv[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h80, 32'h2, 32'h1234CAFE, 1'b0, 32'h0, 4'd4, 32'h20, 32'hCAFEAB44};
        tv[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h83, 32'h0, 32'h00000055, 1'b0, 32'h0, 4'd4, 32'h20, 32'h55FEAB44};
        tv[14] = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h80, 32'h2, 32'h0, 1'b0, 32'h000055FE, 4'd3, 32'h20, 32'h0};
        tv[15] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h2, 32'h0, 1'b1, 32'h0, 4'd1, 32'h0, 32'h0};
        tv[16] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h100, 32'h3, 32'hFFFF, 1'b1, 32'h0, 4'd1, 32'h0, 32'h0};
        tv[17] = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 4'd1, 32'h0, 32'h0};
        tv[18] = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 32'h0, 4'd1, 32'h0, 32'h0};
        tv[19] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0BADF00D, 1'b0, 32'h0, 4'd2, 32'h1, 32'h0BADF00D};
        tv[20] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 32'h0BADF00D, 4'd3, 32'h1, 32'h0};
        tv[21] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h4, 32'h3, 32'h0, 1'b0, 32'h0000000B, 4'd3, 32'h1, 32'h0};
        tv[22] = '{1'b0, 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b0, 32'h00000BAD, 4'd3, 32'h1, 32'h0};
        tv[23] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 32'h12345678, 1'b0, 32'h0, 4'd2, 32'h40, 32'h12345678};
        tv[24] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h2, 32'h0, 1'b0, 32'h12345678, 4'd3, 32'h40, 32'h0};
        tv[25] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h100, 32'h3, 32'h0, 1'b0, 32'h00001234, 4'd3, 32'h40, 32'h0};
        tv[26] = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h100, 32'h1, 32'h0000BEEF, 1'b0, 32'h0, 4'd4, 32'h40, 32'h1234BEEF};
        tv[27] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h3, 32'h0, 1'b0, 32'h1234BEEF, 4'd3, 32'h40, 32'h0};
        tv[28] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 4'd1, 32'h0, 32'h0};
        tv[29] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h100, 32'h1, 32'h0, 1'b0, 32'hFFFFFFBE, 4'd3, 32'h40, 32'h0};

        // reset state, with a request held during reset that must be ignored
        req_valid = 1'b1; req_size = 2'b11;
        #12;
        chk("rst ready", {31'b0, m1.req_ready}, 32'd1);
        chk("rst rsp_valid", {31'b0, m1.rsp_valid}, 32'd0);
        chk("rst rsp_err", {31'b0, m1.rsp_err}, 32'd0);
        chk("rst rsp_data", m1.rsp_data, 32'h0);
        chk("rst mem_addr", m1.mem_addr, 32'h0);
        chk("rst mem_we", {31'b0, m1.mem_we}, 32'd0);
        chk("rst mem_wdata", m1.mem_wdata, 32'h0);
        @(negedge clk);
        req_valid = 1'b0; req_size = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst ignored_req", {31'b0, m1.rsp_valid}, 32'd0);

        for (int i = 0; i < NV; i++) run_vec(tv[i], i);

        // back-to-back: new request accepted in the cycle the error response pulses
        @(negedge clk);
        sel = 1'b0;
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b11; base = 32'h100; offset = 32'h0;
        @(posedge clk);
        #1 req_size = 2'b10; base = 32'h104;
        @(negedge clk);
        chk("b2b err_valid", {31'b0, m1.rsp_valid}, 32'd1);
        chk("b2b err_flag", {31'b0, m1.rsp_err}, 32'd1);
        chk("b2b ready", {31'b0, m1.req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b load_valid", {31'b0, m1.rsp_valid}, 32'd1);
        chk("b2b load_data", m1.rsp_data, 32'h80FF7F01);
        chk("b2b load_err", {31'b0, m1.rsp_err}, 32'd0);

        // reset during the WAIT of a byte store read-modify-write
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; base = 32'h80; offset = 32'h1;
        wdata = 32'h000000EE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rst busy", {31'b0, m1.req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst we_low", {31'b0, m1.mem_we}, 32'd0);
        chk("rmw_rst ready", {31'b0, m1.req_ready}, 32'd1);
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m1.mem_we || m1.rsp_valid) bad = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (m1.mem_we || m1.rsp_valid) bad = 1'b1;
        end
        chk("rmw_rst quiet", {31'b0, bad}, 32'd0);
        chk("rmw_rst ready_after", {31'b0, m1.req_ready}, 32'd1);
        chk("rmw_rst mem_word", mem1[8'h20], 32'h55FEAB44);
        v = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 32'h55FEAB44, 4'd3, 32'h20, 32'h0};
        run_vec(v, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
